// File: rtl/delay_meter.sv
// rtl/delay_meter.sv - cycle-latency meter from a src bus change to a matching dst value.
// Optional min/max statistics are built when DELAY_METER_STATS_EN is defined.
module delay_meter #(
    parameter int WIDTH   = 3,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200      // 1 <= TIMEOUT < 2**CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] dst,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] meas_cycles,
    output logic             meas_timeout,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] min_cycles,
    output logic [CNT_W-1:0] max_cycles,
    input  logic             stats_clr
);

    typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] src_q;
    logic [WIDTH-1:0] target, target_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cycles_nxt;
    logic             timeout_nxt;
    logic             result_hit;
    logic             change;

    assign change = (src != src_q);
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        target_nxt  = target;
        cnt_nxt     = cnt;
        cycles_nxt  = meas_cycles;
        timeout_nxt = meas_timeout;
        result_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && change) begin
                    target_nxt = src;
                    cnt_nxt    = CNT_W'(1);
                    state_nxt  = MEASURE;
                end
            end
            MEASURE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (dst == target) begin
                    cycles_nxt  = cnt;
                    timeout_nxt = 1'b0;
                    result_hit  = 1'b1;
                    state_nxt   = DONE;
                end else if (cnt == TIMEOUT_C) begin
                    cycles_nxt  = TIMEOUT_C;
                    timeout_nxt = 1'b1;
                    state_nxt   = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                // Result stays frozen until taken; enable has no say here.
                if (meas_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            src_q        <= '0;
            target       <= '0;
            cnt          <= '0;
            meas_cycles  <= '0;
            meas_timeout <= 1'b0;
            meas_valid   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_nxt;
            src_q        <= src;
            target       <= target_nxt;
            cnt          <= cnt_nxt;
            meas_cycles  <= cycles_nxt;
            meas_timeout <= timeout_nxt;
            meas_valid   <= (state_nxt == DONE);
            // Any change seen while busy is dropped, including on the handshake edge.
            if (change && state != IDLE) overrun <= 1'b1;
        end
    end

`ifdef DELAY_METER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            min_cycles <= '1;
            max_cycles <= '0;
        end else if (result_hit) begin
            if (cycles_nxt < min_cycles) min_cycles <= cycles_nxt;
            if (cycles_nxt > max_cycles) max_cycles <= cycles_nxt;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = ^{stats_clr, result_hit};
    assign min_cycles   = '1;
    assign max_cycles   = '0;
`endif

endmodule

// File: tb/tb_delay_meter.sv
// tb/tb_delay_meter.sv - directed table and sequence bench for delay_meter.
module tb_delay_meter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] src = '0;
    logic [2:0] dst = '0;
    logic       meas_valid;
    logic       meas_ready = 1'b0;
    logic [7:0] meas_cycles;
    logic       meas_timeout;
    logic       busy;
    logic       overrun;
    logic [7:0] min_cycles;
    logic [7:0] max_cycles;
    logic       stats_clr = 1'b0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    delay_meter #(.WIDTH(3), .CNT_W(8), .TIMEOUT(200)) dut (
        .clk(clk), .reset(reset), .enable(enable), .src(src), .dst(dst),
        .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_cycles(meas_cycles),
        .meas_timeout(meas_timeout), .busy(busy), .overrun(overrun),
        .min_cycles(min_cycles), .max_cycles(max_cycles), .stats_clr(stats_clr)
    );

    typedef struct {
        logic       en;
        logic [2:0] s;
        logic [2:0] d;
        logic       rdy;
        logic       valid;
        logic [7:0] cyc;
        logic       bsy;
        logic       ovr;
        logic [7:0] mn;
        logic [7:0] mx;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [7:0] smin(input logic [7:0] v);
`ifdef DELAY_METER_STATS_EN
        return v;
`else
        return 8'hFF;
`endif
    endfunction

    function automatic logic [7:0] smax(input logic [7:0] v);
`ifdef DELAY_METER_STATS_EN
        return v;
`else
        return 8'h00;
`endif
    endfunction

    function automatic vec_t mk(input logic en, input logic [2:0] s, input logic [2:0] d,
                                input logic rdy, input logic valid, input logic [7:0] cyc,
                                input logic bsy, input logic ovr,
                                input logic [7:0] mn, input logic [7:0] mx);
        vec_t v;
        v.en = en; v.s = s; v.d = d; v.rdy = rdy; v.valid = valid; v.cyc = cyc;
        v.bsy = bsy; v.ovr = ovr; v.mn = smin(mn); v.mx = smax(mx);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic step(input logic en, input logic [2:0] s, input logic [2:0] d,
                        input logic rdy, input logic clr);
        @(negedge clk);
        enable = en; src = s; dst = d; meas_ready = rdy; stats_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    // Capture v, hold dst at 0 for lat-1 edges, then present v: result lat.
    task automatic meas(input logic [2:0] v, input int lat, input logic clr_last);
        step(1, v, 0, 0, 0);
        for (int i = 1; i < lat; i++) step(1, v, 0, 0, 0);
        step(1, v, v, 0, clr_last);
        chk("meas_valid", meas_valid, 1);
        chk("meas_cycles", meas_cycles, lat);
        chk("meas_timeout", meas_timeout, 0);
    endtask

    initial begin
        int n;

        tbl[0]  = mk(1, 4, 0, 1, 0, 0, 1, 0, 8'hFF, 0);
        tbl[1]  = mk(1, 4, 0, 1, 0, 0, 1, 0, 8'hFF, 0);
        tbl[2]  = mk(1, 4, 0, 1, 0, 0, 1, 0, 8'hFF, 0);
        tbl[3]  = mk(1, 4, 4, 1, 1, 3, 1, 0, 3, 3);
        tbl[4]  = mk(1, 4, 4, 1, 0, 0, 0, 0, 3, 3);
        tbl[5]  = mk(1, 1, 1, 0, 0, 0, 1, 0, 3, 3);
        tbl[6]  = mk(1, 1, 1, 0, 1, 1, 1, 0, 1, 3);
        tbl[7]  = mk(1, 1, 1, 0, 1, 1, 1, 0, 1, 3);
        tbl[8]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 1, 3);
        tbl[9]  = mk(0, 2, 0, 0, 0, 0, 0, 0, 1, 3);
        tbl[10] = mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 3);
        tbl[11] = mk(1, 3, 3, 0, 0, 0, 1, 0, 1, 3);
        tbl[12] = mk(1, 3, 3, 0, 1, 1, 1, 0, 1, 3);
        tbl[13] = mk(1, 0, 3, 1, 0, 0, 0, 1, 1, 3);
        tbl[14] = mk(1, 0, 3, 0, 0, 0, 0, 1, 1, 3);

        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cycles", meas_cycles, 0);
        chk("rst_timeout", meas_timeout, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_min", min_cycles, 8'hFF);
        chk("rst_max", max_cycles, 0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].en, tbl[i].s, tbl[i].d, tbl[i].rdy, 0);
            chk($sformatf("row%0d_valid", i), meas_valid, tbl[i].valid);
            chk($sformatf("row%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("row%0d_overrun", i), overrun, tbl[i].ovr);
            chk($sformatf("row%0d_min", i), min_cycles, tbl[i].mn);
            chk($sformatf("row%0d_max", i), max_cycles, tbl[i].mx);
            if (tbl[i].valid) begin
                chk($sformatf("row%0d_cycles", i), meas_cycles, tbl[i].cyc);
                chk($sformatf("row%0d_timeout", i), meas_timeout, 0);
            end
        end

        // Timeout: dst never matches, result arrives 200 edges after capture.
        do_reset();
        step(1, 5, 0, 0, 0);
        n = 0;
        while (!meas_valid && n < 300) begin
            step(1, 5, 0, 0, 0);
            n++;
        end
        chk("to_edges", n, 200);
        chk("to_cycles", meas_cycles, 200);
        chk("to_flag", meas_timeout, 1);
        chk("to_min", min_cycles, 8'hFF);
        chk("to_max", max_cycles, 0);
        step(1, 5, 0, 1, 0);
        chk("to_hs_valid", meas_valid, 0);

        // Overrun during MEASURE plus backpressure in DONE.
        do_reset();
        chk("ov_clear", overrun, 0);
        step(1, 6, 0, 0, 0);
        step(1, 7, 0, 0, 0);
        chk("ov_set", overrun, 1);
        chk("ov_busy", busy, 1);
        step(1, 7, 6, 0, 0);
        chk("ov_valid", meas_valid, 1);
        chk("ov_cycles", meas_cycles, 2);
        for (int i = 0; i < 5; i++) begin
            step(1, 7, 0, 0, 0);
            chk($sformatf("ov_hold%0d_valid", i), meas_valid, 1);
            chk($sformatf("ov_hold%0d_cycles", i), meas_cycles, 2);
        end
        chk("ov_min", min_cycles, smin(2));
        chk("ov_max", max_cycles, smax(2));
        step(1, 7, 0, 1, 0);
        chk("ov_hs_valid", meas_valid, 0);
        step(1, 7, 7, 0, 0);
        chk("ov_no_remeas", busy, 0);
        chk("ov_sticky", overrun, 1);

        // Abort by enable, then reset while a result waits in DONE.
        step(1, 1, 0, 0, 0);
        chk("ab_busy", busy, 1);
        step(0, 1, 0, 0, 0);
        chk("ab_idle", busy, 0);
        step(0, 1, 1, 1, 0);
        chk("ab_no_valid", meas_valid, 0);
        step(1, 2, 2, 0, 0);
        step(1, 2, 2, 0, 0);
        chk("rd_valid", meas_valid, 1);
        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        reset = 1'b0;
        chk("rd_valid_cleared", meas_valid, 0);
        chk("rd_busy", busy, 0);
        chk("rd_overrun", overrun, 0);
        step(0, 0, 0, 0, 0);
        chk("rd_stays_idle", busy, 0);

        // Statistics, and a clear landing on the same edge as a result.
        meas(1, 3, 0);  step(1, 1, 1, 1, 0);
        meas(2, 10, 0); step(1, 2, 2, 1, 0);
        meas(3, 1, 0);  step(1, 3, 3, 1, 0);
        chk("st_min", min_cycles, smin(1));
        chk("st_max", max_cycles, smax(10));
        meas(4, 5, 1);
        chk("st_clr_min", min_cycles, 8'hFF);
        chk("st_clr_max", max_cycles, 0);
        step(1, 4, 4, 1, 0);
        meas(5, 7, 0);
        chk("st_after_min", min_cycles, smin(7));
        chk("st_after_max", max_cycles, smax(7));
        step(1, 5, 5, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
